// File: rtl/core_pkg.sv
// Core-wide constants shared by the front end: reset fetch address, canonical NOP, instruction width.
package core_pkg;

  localparam int unsigned INSTR_W        = 32;
  localparam logic [63:0] CORE_RESET_PC  = 64'h0000_0000_8000_0000;
  localparam logic [31:0] CORE_NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with registered head; push->head latency 1 cycle, flush clears in one cycle.
// Push is dropped when full unless a pop happens in the same cycle; pop is ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifu_fq.sv
// Instruction fetch: issues sequential PCs, tags responses in order, buffers {pc,instr} for decode.
// Response->output latency 1 cycle; requests are credit-limited so every response has a queue slot.
module ifu_fq
  import core_pkg::*;
#(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(CORE_RESET_PC),
  parameter int              FQ_DEPTH  = 4,
  parameter logic [31:0]     NOP_INSTR = CORE_NOP_INSTR
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_instr,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_snxt_pc,
  output logic [31:0]     out_instr
);

  localparam int          CW         = $clog2(FQ_DEPTH + 1);
  localparam logic [CW:0] CREDIT_LIM = (CW + 1)'(FQ_DEPTH);

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   inflight_q;
  logic [CW-1:0]   inflight_nxt;
  logic [CW-1:0]   discard_q;

  logic            req_fire;
  logic            rsp_dec;
  logic            rsp_keep;
  logic            fq_pop;
  logic            credit_ok;

  logic [XLEN-1:0] tag_pc;
  logic            tag_full;
  logic            tag_empty;
  logic [CW-1:0]   tag_count;

  fq_entry_t       fq_in;
  fq_entry_t       fq_head;
  logic            fq_full;
  logic            fq_empty;
  logic [CW-1:0]   fq_count;

  logic            unused_tag_count;
  assign unused_tag_count = ^tag_count;

  // Outstanding requests (including ones to be discarded) plus buffered entries never exceed the queue.
  assign credit_ok      = ({1'b0, inflight_q} + {1'b0, fq_count}) < CREDIT_LIM;
  assign imem_req_valid = rstn & ~redirect_en & credit_ok & ~tag_full;
  assign imem_req_addr  = pc_q;
  assign pc             = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // A response with nothing outstanding is ignored so the counters cannot wrap.
  assign rsp_dec  = imem_rsp_valid & (inflight_q != '0);
  assign rsp_keep = rsp_dec & ~redirect_en & (discard_q == '0) & ~tag_empty
                  & (~fq_full | fq_pop);

  assign inflight_nxt = inflight_q + CW'(req_fire) - CW'(rsp_dec);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      if (redirect_en)   pc_q <= redirect_pc;
      else if (req_fire) pc_q <= pc_q + XLEN'(4);

      inflight_q <= inflight_nxt;

      // Everything still outstanding after a redirect belongs to the old stream.
      if (redirect_en)                        discard_q <= inflight_nxt;
      else if (rsp_dec && discard_q != '0)    discard_q <= discard_q - CW'(1);
    end
  end

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FQ_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (rsp_keep),
    .flush     (redirect_en),
    .head      (tag_pc),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  assign fq_in.pc    = tag_pc;
  assign fq_in.instr = imem_rsp_instr;

  assign out_valid = rstn & ~fq_empty;
  assign fq_pop    = out_valid & out_ready & ~redirect_en;

  sync_fifo #(
    .WIDTH ($bits(fq_entry_t)),
    .DEPTH (FQ_DEPTH)
  ) u_fetch_q (
    .clk       (clk),
    .rstn      (rstn),
    .push      (rsp_keep),
    .push_data (fq_in),
    .pop       (fq_pop),
    .flush     (redirect_en),
    .head      (fq_head),
    .full      (fq_full),
    .empty     (fq_empty),
    .count     (fq_count)
  );

  assign out_pc      = out_valid ? fq_head.pc : '0;
  assign out_snxt_pc = out_valid ? fq_head.pc + XLEN'(4) : '0;
  assign out_instr   = out_valid ? fq_head.instr : NOP_INSTR;

endmodule

// File: tb/tb_ifu_fq.sv
// Bench for ifu_fq: in-order memory model with random latency, PC-sequence scoreboard per redirect epoch.
module tb_ifu_fq;

  localparam int          XLEN   = 64;
  localparam int          DEPTH  = 4;
  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rstn;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid = 1'b0;
  logic [31:0]     imem_rsp_instr = '0;
  logic            redirect_en;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_snxt_pc;
  logic [31:0]     out_instr;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ifu_fq #(
    .XLEN      (XLEN),
    .RESET_PC  (RST_PC),
    .FQ_DEPTH  (DEPTH),
    .NOP_INSTR (NOP)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_instr (imem_rsp_instr),
    .redirect_en    (redirect_en),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_snxt_pc    (out_snxt_pc),
    .out_instr      (out_instr)
  );

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0003;
  endfunction

  // Memory: records accepted requests, answers strictly in order after 1..mem_lat_max cycles.
  logic [63:0] mq_addr[$];
  int          mq_due[$];
  int          cyc         = 0;
  int          mem_lat_max = 1;
  bit          rsp_en      = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      mq_addr.delete();
      mq_due.delete();
    end else if (imem_req_valid && imem_req_ready) begin
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(cyc + int'($urandom_range(mem_lat_max, 1)) - 1);
    end
  end

  always @(posedge clk) begin
    #2;
    if (rsp_en && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_instr = instr_of(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_instr = $urandom();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; redirect_en = 1'b0; imem_req_ready = 1'b0; out_ready = 1'b0;
    rsp_en = 1'b1; mem_lat_max = 1;
    tick(); tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; redirect_en = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();
    @(negedge clk);
    total_cnt++; if (pc !== RST_PC) $display("FAIL reset_pc: got %h expected %h", pc, RST_PC); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_instr !== NOP) $display("FAIL reset_out_instr: got %h expected %h", out_instr, NOP); else pass_cnt++;
    total_cnt++; if (out_pc !== 64'h0) $display("FAIL reset_out_pc: got %h expected 0", out_pc); else pass_cnt++;
    total_cnt++; if (out_snxt_pc !== 64'h0) $display("FAIL reset_out_snxt_pc: got %h expected 0", out_snxt_pc); else pass_cnt++;
    total_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); else pass_cnt++;
    tick();
    rstn = 1'b1;
    @(negedge clk);
    total_cnt++; if (imem_req_valid !== 1'b1) $display("FAIL release_req_valid: got %b expected 1", imem_req_valid); else pass_cnt++;
    total_cnt++; if (imem_req_addr !== RST_PC) $display("FAIL release_req_addr: got %h expected %h", imem_req_addr, RST_PC); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL release_out_valid: got %b expected 0", out_valid); else pass_cnt++;
    tick();
  endtask

  task automatic test_stream();
    logic [63:0] exp_fetch;
    logic [63:0] exp_out;
    exp_fetch = RST_PC;
    exp_out   = RST_PC;
    do_reset();
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      total_cnt++; if (imem_req_valid !== 1'b1) $display("FAIL stream_req_valid: cycle %0d got %b expected 1", i, imem_req_valid); else pass_cnt++;
      total_cnt++; if (imem_req_addr !== exp_fetch) $display("FAIL stream_req_addr: got %h expected %h", imem_req_addr, exp_fetch); else pass_cnt++;
      exp_fetch += 64'd4;
      if (i < 2) begin
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL stream_no_bypass: cycle %0d got %b expected 0", i, out_valid); else pass_cnt++;
        total_cnt++; if (out_instr !== NOP) $display("FAIL stream_nop: got %h expected %h", out_instr, NOP); else pass_cnt++;
      end else begin
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL stream_out_valid: cycle %0d got %b expected 1", i, out_valid); else pass_cnt++;
        total_cnt++; if (out_pc !== exp_out) $display("FAIL stream_out_pc: got %h expected %h", out_pc, exp_out); else pass_cnt++;
        total_cnt++; if (out_instr !== instr_of(exp_out)) $display("FAIL stream_out_instr: got %h expected %h", out_instr, instr_of(exp_out)); else pass_cnt++;
        total_cnt++; if (out_snxt_pc !== exp_out + 64'd4) $display("FAIL stream_snxt: got %h expected %h", out_snxt_pc, exp_out + 64'd4); else pass_cnt++;
        exp_out += 64'd4;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int          fires;
    int          pops;
    logic [63:0] exp_out;
    fires = 0;
    pops  = 0;
    exp_out = RST_PC;
    do_reset();
    imem_req_ready = 1'b1;
    out_ready      = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) fires++;
      if (i >= 2) begin
        total_cnt++; if (out_pc !== RST_PC) $display("FAIL bp_head_stable: cycle %0d got %h expected %h", i, out_pc, RST_PC); else pass_cnt++;
      end
      tick();
    end
    @(negedge clk);
    total_cnt++; if (fires !== DEPTH) $display("FAIL bp_fire_count: got %0d expected %0d", fires, DEPTH); else pass_cnt++;
    total_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL bp_req_valid_low: got %b expected 0", imem_req_valid); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid: got %b expected 1", out_valid); else pass_cnt++;
    tick();
    imem_req_ready = 1'b0;
    out_ready      = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        total_cnt++; if (out_pc !== exp_out) $display("FAIL bp_drain_pc: got %h expected %h", out_pc, exp_out); else pass_cnt++;
        exp_out += 64'd4;
        pops++;
      end
      tick();
    end
    @(negedge clk);
    total_cnt++; if (pops !== DEPTH) $display("FAIL bp_held_entries: got %0d expected %0d", pops, DEPTH); else pass_cnt++;
    tick();
  endtask

  task automatic test_redirect();
    logic [63:0] exp_out;
    int          pops;
    exp_out = 64'h8000_1000;
    pops    = 0;
    do_reset();
    rsp_en         = 1'b0;
    out_ready      = 1'b1;
    imem_req_ready = 1'b1;
    @(negedge clk); tick();
    @(negedge clk); tick();
    imem_req_ready = 1'b0;
    redirect_en    = 1'b1;
    redirect_pc    = 64'h8000_1000;
    @(negedge clk);
    total_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL redir_blocks_req: got %b expected 0", imem_req_valid); else pass_cnt++;
    tick();
    redirect_en    = 1'b0;
    imem_req_ready = 1'b1;
    rsp_en         = 1'b1;
    @(negedge clk);
    total_cnt++; if (pc !== 64'h8000_1000) $display("FAIL redir_pc: got %h expected 80001000", pc); else pass_cnt++;
    tick();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        total_cnt++; if (out_pc !== exp_out) $display("FAIL redir_out_pc: got %h expected %h", out_pc, exp_out); else pass_cnt++;
        total_cnt++; if (out_instr !== instr_of(exp_out)) $display("FAIL redir_out_instr: got %h expected %h", out_instr, instr_of(exp_out)); else pass_cnt++;
        exp_out += 64'd4;
        pops++;
      end
      tick();
    end
    @(negedge clk);
    total_cnt++; if (pops < 6) $display("FAIL redir_progress: got %0d pops expected at least 6", pops); else pass_cnt++;
    tick();
  endtask

  task automatic test_collision();
    logic [63:0] exp_out;
    logic [63:0] exp_fetch;
    int          fires;
    int          pops;
    exp_out   = 64'h8000_2000;
    exp_fetch = 64'h8000_2000;
    fires = 0;
    pops  = 0;
    do_reset();
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    repeat (6) begin
      @(negedge clk);
      tick();
    end
    redirect_en = 1'b1;
    redirect_pc = 64'h8000_2000;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL coll_pop_pending: got %b expected 1", out_valid); else pass_cnt++;
    total_cnt++; if (imem_rsp_valid !== 1'b1) $display("FAIL coll_rsp_pending: got %b expected 1", imem_rsp_valid); else pass_cnt++;
    tick();
    redirect_en = 1'b0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        total_cnt++; if (imem_req_addr !== exp_fetch) $display("FAIL coll_req_addr: got %h expected %h", imem_req_addr, exp_fetch); else pass_cnt++;
        exp_fetch += 64'd4;
        fires++;
      end
      if (out_valid && out_ready) begin
        total_cnt++; if (out_pc !== exp_out) $display("FAIL coll_out_pc: got %h expected %h", out_pc, exp_out); else pass_cnt++;
        exp_out += 64'd4;
        pops++;
      end
      tick();
      if (i == 9) imem_req_ready = 1'b0;
    end
    @(negedge clk);
    total_cnt++; if (pops !== fires || pops == 0) $display("FAIL coll_no_loss: got %0d pops expected %0d (nonzero)", pops, fires); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL coll_drained: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (imem_req_valid !== 1'b1) $display("FAIL coll_credit_restored: got %b expected 1", imem_req_valid); else pass_cnt++;
    tick();
  endtask

  task automatic test_random();
    logic [63:0] exp_fetch;
    logic [63:0] exp_out;
    logic [31:0] r;
    int          fires;
    int          pops;
    bit          drain;
    exp_fetch = RST_PC;
    exp_out   = RST_PC;
    fires = 0;
    pops  = 0;
    do_reset();
    mem_lat_max = 3;
    for (int i = 0; i < 700; i++) begin
      drain          = (i >= 660);
      imem_req_ready = drain ? 1'b0 : ($urandom_range(1, 0) == 1);
      out_ready      = drain ? 1'b1 : ($urandom_range(9, 0) < 6);
      rsp_en         = drain ? 1'b1 : ($urandom_range(9, 0) < 7);
      redirect_en    = !drain && ($urandom_range(99, 0) < 3);
      r              = $urandom() & 32'hFFFF_FFFC;
      redirect_pc    = {32'h0, r};
      @(negedge clk);
      if (redirect_en) begin
        total_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL rand_redir_req: got %b expected 0", imem_req_valid); else pass_cnt++;
        exp_fetch = redirect_pc;
        exp_out   = redirect_pc;
        fires = 0;
        pops  = 0;
      end else begin
        total_cnt++; if (pc !== exp_fetch) $display("FAIL rand_pc: got %h expected %h", pc, exp_fetch); else pass_cnt++;
        if (imem_req_valid && imem_req_ready) begin
          exp_fetch += 64'd4;
          fires++;
        end
        if (out_valid && out_ready) begin
          total_cnt++; if (out_pc !== exp_out) $display("FAIL rand_out_pc: got %h expected %h", out_pc, exp_out); else pass_cnt++;
          total_cnt++; if (out_instr !== instr_of(exp_out)) $display("FAIL rand_out_instr: got %h expected %h", out_instr, instr_of(exp_out)); else pass_cnt++;
          total_cnt++; if (out_snxt_pc !== exp_out + 64'd4) $display("FAIL rand_snxt: got %h expected %h", out_snxt_pc, exp_out + 64'd4); else pass_cnt++;
          exp_out += 64'd4;
          pops++;
        end else if (!out_valid) begin
          total_cnt++; if (out_instr !== NOP) $display("FAIL rand_idle_nop: got %h expected %h", out_instr, NOP); else pass_cnt++;
        end
      end
      tick();
    end
    @(negedge clk);
    total_cnt++; if (pops !== fires) $display("FAIL rand_no_loss: got %0d pops expected %0d", pops, fires); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rand_drained: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (imem_req_valid !== 1'b1) $display("FAIL rand_credit_restored: got %b expected 1", imem_req_valid); else pass_cnt++;
    tick();
  endtask

  task automatic test_mid_reset();
    logic [63:0] exp_out;
    int          pops;
    exp_out = RST_PC;
    pops    = 0;
    do_reset();
    imem_req_ready = 1'b1;
    out_ready      = 1'b0;
    repeat (8) begin
      @(negedge clk);
      tick();
    end
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL midrst_full_before: got %b expected 1", out_valid); else pass_cnt++;
    tick();
    rstn = 1'b0;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL midrst_during_out_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL midrst_during_req_valid: got %b expected 0", imem_req_valid); else pass_cnt++;
    tick();
    rstn = 1'b1;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (pc !== RST_PC) $display("FAIL midrst_pc: got %h expected %h", pc, RST_PC); else pass_cnt++;
    total_cnt++; if (out_pc !== 64'h0) $display("FAIL midrst_out_pc: got %h expected 0", out_pc); else pass_cnt++;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        total_cnt++; if (out_pc !== exp_out) $display("FAIL midrst_out_seq: got %h expected %h", out_pc, exp_out); else pass_cnt++;
        exp_out += 64'd4;
        pops++;
      end
      tick();
    end
    @(negedge clk);
    total_cnt++; if (pops < 4) $display("FAIL midrst_progress: got %0d pops expected at least 4", pops); else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn           = 1'b0;
    imem_req_ready = 1'b0;
    redirect_en    = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_collision();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
